// File: rtl/unum4_denorm_pkg.sv
// Shared FSM encoding and helpers for the unum4 denormaliser.
package unum4_denorm_pkg;

  localparam int UNUM4_DENORM_STATE_W = 2;

  typedef enum logic [UNUM4_DENORM_STATE_W-1:0] {
    UNUM4_DENORM_IDLE  = 2'd0,
    UNUM4_DENORM_SHIFT = 2'd1,
    UNUM4_DENORM_DONE  = 2'd2
  } unum4_denorm_state_e;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/unum4_sra_step.sv
// One combinational arithmetic right-shift step of at most STEP bits,
// plus the OR of every bit that falls off the bottom.
module unum4_sra_step
  import unum4_denorm_pkg::*;
#(
  parameter int DW   = 29,
  parameter int STEP = 4,
  localparam int KW  = $clog2(STEP + 1)
) (
  input  logic [DW-1:0] data_i,
  input  logic [KW-1:0] k_i,
  output logic [DW-1:0] data_o,
  output logic          lost_o
);

  assign data_o = $signed(data_i) >>> k_i;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    lost_o = 1'b0;
    for (int i = 0; i < DW; i++) begin
      if (i < int'(k_i)) lost_o = lost_o | data_i[i];
    end
  end

endmodule

// File: rtl/unum4_denorm.sv
// Iterative sign-filling right shifter for exponent alignment in unum4.
// Define UNUM4_DENORM_STICKY_EN to build the sticky accumulator; otherwise sticky is tied low.
module unum4_denorm
  import unum4_denorm_pkg::*;
#(
  parameter int MAN_MAX_W = 29,
  parameter int EXP_MAX_W = 16,
  parameter int EXTRA     = 0,
  parameter int STEP      = 4,
  localparam int DW       = MAN_MAX_W + EXTRA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        data_in,
  input  logic [EXP_MAX_W-1:0] shift,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        data_out,
  output logic                 sticky
);

  localparam int RW = $clog2(DW + 1);
  localparam int KW = $clog2(STEP + 1);

  unum4_denorm_state_e state_q, state_d;
  logic [RW-1:0]       rem_q, rem_d;
  logic [DW-1:0]       data_q, data_d;
  logic [KW-1:0]       k;
  logic [DW-1:0]       step_data;
  logic                step_lost;
  logic                accept;

  assign accept    = in_valid && (state_q == UNUM4_DENORM_IDLE);
  assign in_ready  = (state_q == UNUM4_DENORM_IDLE);
  assign out_valid = (state_q == UNUM4_DENORM_DONE);
  assign data_out  = data_q;
  assign k         = (rem_q > RW'(STEP)) ? KW'(STEP) : KW'(rem_q);

  unum4_sra_step #(.DW(DW), .STEP(STEP)) u_step (
    .data_i (data_q),
    .k_i    (k),
    .data_o (step_data),
    .lost_o (step_lost)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    data_d  = data_q;
    unique case (state_q)
      UNUM4_DENORM_IDLE: begin
        if (accept) begin
          data_d  = data_in;
          rem_d   = RW'(min_u(32'(shift), DW));
          state_d = (shift == '0) ? UNUM4_DENORM_DONE : UNUM4_DENORM_SHIFT;
        end
      end
      UNUM4_DENORM_SHIFT: begin
        data_d = step_data;
        rem_d  = rem_q - RW'(k);
        if (rem_d == '0) state_d = UNUM4_DENORM_DONE;
      end
      UNUM4_DENORM_DONE: begin
        if (out_ready) state_d = UNUM4_DENORM_IDLE;
      end
      default: state_d = UNUM4_DENORM_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNUM4_DENORM_IDLE;
      rem_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
    end
  end

`ifdef UNUM4_DENORM_STICKY_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (accept) sticky_d = 1'b0;
    else if (state_q == UNUM4_DENORM_SHIFT) sticky_d = sticky_q | step_lost;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign sticky = sticky_q;
`else
  logic unused_lost;
  assign unused_lost = step_lost;
  assign sticky      = 1'b0;
`endif

endmodule

// File: tb/tb_unum4_denorm.sv
// Directed and small random checks of the unum4 denormaliser at DW=29, STEP=4.
module tb_unum4_denorm;

  localparam int DW = 29;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] data_in = '0;
  logic [15:0]   shift = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] data_out;
  logic          sticky;

  int n_checks = 0;
  int n_errors = 0;

  unum4_denorm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .shift     (shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .sticky    (sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic exp_sticky(input logic s);
`ifdef UNUM4_DENORM_STICKY_EN
    return s;
`else
    return 1'b0 & s;
`endif
  endfunction

  task automatic issue(input string tag, input logic [DW-1:0] d, input logic [15:0] s);
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    data_in  = d;
    shift    = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in  = '1;
    shift    = '1;
  endtask

  // Accepting edge counts as edge 1.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [DW-1:0] d, input logic [15:0] s,
                     input logic [DW-1:0] exp_d, input logic exp_s, input int exp_lat);
    int lat;
    issue(tag, d, s);
    wait_valid(lat);
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".data"}, 64'(data_out), 64'(exp_d));
    check({tag, ".sticky"}, 64'(sticky), 64'(exp_sticky(exp_s)));
    @(posedge clk);
    #1;
    check({tag, ".back_idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [DW-1:0] held;
    int lat;

    #12;
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.data_out", 64'(data_out), 64'd0);
    check("reset.sticky", 64'(sticky), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run("t1", 29'h0800_0001, 16'd5, 29'h0040_0000, 1'b1, 3);
    run("t2", 29'h1000_0000, 16'd3, 29'h1E00_0000, 1'b0, 2);
    run("t3pos", 29'h0FFF_FFFF, 16'd40, 29'h0000_0000, 1'b1, 9);
    run("t3neg", 29'h1000_0000, 16'd40, 29'h1FFF_FFFF, 1'b1, 9);
    run("t3edge", 29'h1234_5678, 16'd29, 29'h1FFF_FFFF, 1'b1, 9);
    run("t4", 29'h0ABC_DEF0, 16'd0, 29'h0ABC_DEF0, 1'b0, 1);

    // Back-pressure: result held, new requests refused.
    out_ready = 1'b0;
    issue("t5", 29'h0000_00F3, 16'd4);
    wait_valid(lat);
    check("t5.latency", 64'(lat), 64'd2);
    held = data_out;
    check("t5.data", 64'(held), 64'h0F);
    check("t5.sticky", 64'(sticky), 64'(exp_sticky(1'b1)));
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      data_in  = 29'h1555_5555;
      shift    = 16'd1;
      @(posedge clk);
      #1;
      check("t5.hold_valid", 64'(out_valid), 64'd1);
      check("t5.hold_data", 64'(data_out), 64'(held));
      check("t5.hold_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t5.released_valid", 64'(out_valid), 64'd0);
    check("t5.released_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset in the middle of a long shift.
    issue("t6", 29'h0ABC_DEF0, 16'd20);
    @(posedge clk);
    #1;
    check("t6.busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("t6.rst_valid", 64'(out_valid), 64'd0);
    check("t6.rst_ready", 64'(in_ready), 64'd1);
    check("t6.rst_data", 64'(data_out), 64'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("t6after", 29'h0ABC_DEF0, 16'd20, 29'h0000_00AB, 1'b1, 6);

    // Random vectors against a mask-based model.
    for (int n = 0; n < 20; n++) begin
      logic signed [DW-1:0] d;
      logic [DW-1:0] e;
      int s, sc;
      logic [63:0] mask;
      d    = DW'($urandom);
      s    = $urandom_range(0, 35);
      sc   = (s > DW) ? DW : s;
      e    = d >>> sc;
      mask = (64'd1 << sc) - 64'd1;
      run($sformatf("rnd%0d", n), d, 16'(s), e, |(64'(d) & mask), (sc + 3) / 4 + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
